muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer for the EX stage (MULT, MULTU, DIV, DIVU).
//  It accepts operands from the forwarded EX operand muxes and runs a shift-add or

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_if.sv | 50 +++++
 rtl/muldiv_iter_core.sv | 37 +++
 rtl/muldiv_seq.sv | 144 ++++++++++++++
 tb/tb_muldiv_seq.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Op select values, FSM states and the default datapath width.
package muldiv_pkg;

  localparam int MULDIV_DATA_W = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> muldiv sequencer bundle.
// MULDIV_DIVZERO_EXC_EN adds the o_div_zero flag.
interface muldiv_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
);

  logic              i_start;
  logic [OP_W-1:0]   i_op;
  logic [DATA_W-1:0] i_operand_a;
  logic [DATA_W-1:0] i_operand_b;
  logic              i_flush;
  logic              o_stall_E;
  logic              o_busy;
  logic              o_done;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;
`ifdef MULDIV_DIVZERO_EXC_EN
  logic              o_div_zero;

  modport master (
    output i_start, i_op, i_operand_a,
    output i_operand_b, i_flush,
    input  o_stall_E, o_busy, o_done,
    input  o_hi, o_lo, o_div_zero
  );

  modport slave (
    input  i_start, i_op, i_operand_a,
    input  i_operand_b, i_flush,
    output o_stall_E, o_busy, o_done,
    output o_hi, o_lo, o_div_zero
  );
`else
  modport master (
    output i_start, i_op, i_operand_a,
    output i_operand_b, i_flush,
    input  o_stall_E, o_busy, o_done,
    input  o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_operand_a,
    input  i_operand_b, i_flush,
    output o_stall_E, o_busy, o_done,
    output o_hi, o_lo
  );
`endif

endinterface

// File: rtl/muldiv_iter_core.sv
// One radix-2 step on the {acc, q} pair:
// shift-add multiply or restoring divide.
module muldiv_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] acc_n,
  output logic [DATA_W-1:0] q_n
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] sh;
  logic [DATA_W:0] mx;
  logic            ge;

  always_comb begin
    mx    = {1'b0, m};
    sum   = {1'b0, acc} + (q[0] ? mx : '0);
    sh    = {acc, q[DATA_W-1]};
    ge    = (sh >= mx);
    acc_n = '0;
    q_n   = '0;
    if (is_div) begin
      // remainder always < divisor, so the top bit drops out
      acc_n = ge ? DATA_W'(sh - mx)
                 : sh[DATA_W-1:0];
      q_n   = {q[DATA_W-2:0], ge};
    end else begin
      acc_n = sum[DATA_W:1];
      q_n   = {sum[0], q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// MULDIV_DIVZERO_EXC_EN: fast divide-by-zero exit + o_div_zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MULDIV_DATA_W,
  parameter int OP_W   = 2,
  parameter int CNT_W  = 6
) (
  input logic     i_clk,
  input logic     i_reset,
  muldiv_if.slave bus
);

  state_e            state;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q, m_q;
  logic [DATA_W-1:0] acc_q, q_q;
  logic [DATA_W-1:0] acc_n, q_n;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W-1:0] quo, rem;
  logic [2*DATA_W-1:0] prod;
  logic [CNT_W-1:0]  cnt_q;
  logic neg_q, neg_r, busy_q, done_q;
  logic is_div, sa, sb, b_zero;
`ifdef MULDIV_DIVZERO_EXC_EN
  logic dz_q;
  assign bus.o_div_zero = dz_q;
`endif

  assign is_div = op_q inside {OP_DIV, OP_DIVU};
  assign sa     = (op_q inside {OP_MULT, OP_DIV})
                & a_q[DATA_W-1];
  assign sb     = (op_q inside {OP_MULT, OP_DIV})
                & b_q[DATA_W-1];
  assign a_abs  = sa ? -a_q : a_q;
  assign b_abs  = sb ? -b_q : b_q;
  assign b_zero = (b_q == '0);
  assign prod   = neg_q ? -{acc_q, q_q}
                        : {acc_q, q_q};
  assign quo    = neg_q ? -q_q : q_q;
  assign rem    = neg_r ? -acc_q : acc_q;

  muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
    .is_div (is_div),
    .acc    (acc_q),
    .q      (q_q),
    .m      (m_q),
    .acc_n  (acc_n),
    .q_n    (q_n)
  );

  assign bus.o_stall_E = busy_q
    | (state == S_IDLE && bus.i_start && !bus.i_flush);
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MULDIV_DIVZERO_EXC_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_EXC_EN
      dz_q   <= 1'b0;
`endif
      if (busy_q && bus.i_flush) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.i_start && !bus.i_flush) begin
              op_q   <= bus.i_op;
              a_q    <= bus.i_operand_a;
              b_q    <= bus.i_operand_b;
              busy_q <= 1'b1;
              state  <= S_PREP;
            end
          end
          S_PREP: begin
`ifdef MULDIV_DIVZERO_EXC_EN
            if (is_div && b_zero) begin
              busy_q <= 1'b0;
              done_q <= 1'b0 | 1'b1;
              dz_q   <= 1'b1;
              state  <= S_DONE;
            end else begin
`else
            begin
`endif
              acc_q <= '0;
              q_q   <= is_div ? a_abs : b_abs;
              m_q   <= is_div ? b_abs : a_abs;
              // x/0 keeps an all-ones quotient
              neg_q <= (sa ^ sb) & ~(is_div & b_zero);
              neg_r <= sa;
              cnt_q <= CNT_W'(DATA_W);
              state <= S_ITER;
            end
          end
          S_ITER: begin
            acc_q <= acc_n;
            q_q   <= q_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state <= S_FIX;
          end
          S_FIX: begin
            if (is_div) begin
              hi_q <= rem;
              lo_q <= quo;
            end else begin
              {hi_q, lo_q} <= prod;
            end
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: per-cycle timeline/arithmetic
// model plus hand-computed literal results.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset, start, flush;
  logic [1:0]  op_s;
  logic [31:0] a_s, b_s;
  logic        busy, done, stall, dz;
  logic [31:0] hi, lo;
  logic        armed;
  int          total, bad;

  // model state: t = cycles since accept, -1 when idle
  int          t, done_at;
  logic [31:0] mhi, mlo, ph, pl;
  logic        pdz;

  muldiv_if #(.DATA_W(32), .OP_W(2)) bus ();

  muldiv_seq #(.DATA_W(32), .OP_W(2), .CNT_W(6)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  assign bus.i_start     = start;
  assign bus.i_op        = op_s;
  assign bus.i_operand_a = a_s;
  assign bus.i_operand_b = b_s;
  assign bus.i_flush     = flush;
  assign busy  = bus.o_busy;
  assign done  = bus.o_done;
  assign stall = bus.o_stall_E;
  assign hi    = bus.o_hi;
  assign lo    = bus.o_lo;
`ifdef MULDIV_DIVZERO_EXC_EN
  assign dz    = bus.o_div_zero;
`else
  assign dz    = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic calc(input logic [1:0] op,
                      input logic [31:0] a, b,
                      output logic [31:0] h, l,
                      output logic z);
    longint x, y, p;
    logic [63:0] u;
    x = $signed(a);
    y = $signed(b);
    z = 1'b0;
    h = 32'h0;
    l = 32'h0;
    if (op == OP_MULT) begin
      p = x * y;
      {h, l} = p;
    end else if (op == OP_MULTU) begin
      u = {32'h0, a} * {32'h0, b};
      {h, l} = u;
    end else if (b == 32'h0) begin
`ifdef MULDIV_DIVZERO_EXC_EN
      z = 1'b1;
`else
      l = 32'hFFFF_FFFF;
      h = a;
`endif
    end else if (op == OP_DIV) begin
      p = x / y;
      l = p[31:0];
      p = x % y;
      h = p[31:0];
    end else begin
      l = a / b;
      h = a % b;
    end
  endtask

  always @(negedge clk) begin : cmp
    logic eb, ed, es;
    if (armed) begin
      eb = (t >= 1 && t < done_at);
      ed = (t >= 1 && t == done_at);
      if (ed && !pdz) begin
        mhi = ph;
        mlo = pl;
      end
      es = eb || (t < 0 && start && !flush);
      chk("busy",  64'(busy),  64'(eb));
      chk("done",  64'(done),  64'(ed));
      chk("stall", 64'(stall), 64'(es));
      chk("hi",    64'(hi),    64'(mhi));
      chk("lo",    64'(lo),    64'(mlo));
      chk("divz",  64'(dz),    64'(ed && pdz));
      if (reset) begin
        t = -1;
        mhi = 32'h0;
        mlo = 32'h0;
      end else if (t < 0) begin
        if (start && !flush) begin
          calc(op_s, a_s, b_s, ph, pl, pdz);
          done_at = pdz ? 2 : 35;
          t = 1;
        end
      end else if (t == done_at || flush) begin
        t = -1;
      end else begin
        t++;
      end
    end
  end

  task automatic do_op(input logic [1:0] op,
                       input logic [31:0] a, b,
                       input int flush_at, hold_to,
                       input int rst_at, ncyc,
                       output int done_cyc,
                       output int stall_n);
    done_cyc = -1;
    stall_n  = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    op_s  = op;
    a_s   = a;
    b_s   = b;
    for (int c = 0; c < ncyc; c++) begin
      flush = (c == flush_at);
      reset = (c == rst_at);
      if (c > 0) begin
        if (c <= hold_to) begin
          start = 1'b1;
          op_s  = OP_MULTU;
          a_s   = 32'd2;
          b_s   = 32'd3;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      if (stall) stall_n++;
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int dc, sn;
    total = 0;
    bad   = 0;
    armed = 1'b0;
    t = -1;
    done_at = 35;
    mhi = 32'h0;
    mlo = 32'h0;
    ph  = 32'h0;
    pl  = 32'h0;
    pdz = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op_s  = OP_MULT;
    a_s   = 32'h0;
    b_s   = 32'h0;
    @(posedge clk);
    #1 armed = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi",   64'(hi),   64'h0);
    chk("rst_lo",   64'(lo),   64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          -1, 0, -1, 60, dc, sn);
    chk("mulu_done_cyc", 64'(dc), 64'd35);
    chk("mulu_stall_n",  64'(sn), 64'd35);
    chk("mulu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("mulu_lo", 64'(lo), 64'h0000_0001);

    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7,
          -1, 0, -1, 60, dc, sn);
    chk("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);

    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000,
          -1, 0, -1, 60, dc, sn);
    chk("mult_min_hi", 64'(hi), 64'h4000_0000);
    chk("mult_min_lo", 64'(lo), 64'h0);

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2,
          -1, 0, -1, 60, dc, sn);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    do_op(OP_DIVU, 32'd100, 32'd7,
          -1, 0, -1, 60, dc, sn);
    chk("divu_lo", 64'(lo), 64'h0000_000E);
    chk("divu_hi", 64'(hi), 64'h0000_0002);

    do_op(OP_MULTU, 32'd3, 32'd4,
          10, 0, -1, 45, dc, sn);
    chk("flush_no_done", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("flush_hi", 64'(hi), 64'h0000_0002);
    chk("flush_lo", 64'(lo), 64'h0000_000E);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          -1, 0, -1, 60, dc, sn);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'h0);

    do_op(OP_DIV, 32'd5, 32'd0,
          -1, 0, -1, 60, dc, sn);
`ifdef MULDIV_DIVZERO_EXC_EN
    chk("dz_done_cyc", 64'(dc), 64'd2);
    chk("dz_lo", 64'(lo), 64'h8000_0000);
    chk("dz_hi", 64'(hi), 64'h0);
`else
    chk("dz_done_cyc", 64'(dc), 64'd35);
    chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("dz_hi", 64'(hi), 64'h0000_0005);
`endif

    do_op(OP_DIVU, 32'd1000, 32'd10,
          -1, 25, -1, 60, dc, sn);
    chk("hold_done_cyc", 64'(dc), 64'd35);
    chk("hold_lo", 64'(lo), 64'h0000_0064);
    chk("hold_hi", 64'(hi), 64'h0);

    do_op(OP_MULT, 32'd6, 32'hFFFF_FFF9,
          -1, 0, -1, 60, dc, sn);
    chk("fresh_lo", 64'(lo), 64'hFFFF_FFD6);
    chk("fresh_hi", 64'(hi), 64'hFFFF_FFFF);

    do_op(OP_MULTU, 32'd5, 32'd5,
          -1, 0, 15, 16, dc, sn);
    chk("rstmid_busy",  64'(busy),  64'h0);
    chk("rstmid_stall", 64'(stall), 64'h0);
    chk("rstmid_hi",    64'(hi),    64'h0);
    chk("rstmid_lo",    64'(lo),    64'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
